// File: rtl/ann_pkg.sv
// ---------------------------------------------------------------------------
// ann_pkg
// Shared types and constants for the inference scoring stage.
//   tracker_state_t : control states of accuracy_tracker
//   PERCENT_SCALE   : multiplier that turns a correct/total ratio into percent
//   ACC_W_DEFAULT   : default width of the accuracy output (holds 0..100)
// ---------------------------------------------------------------------------
package ann_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_RES,
      COMPARE,
      DIVIDE,
      NEXT,
      DONE
   } tracker_state_t;

   localparam int PERCENT_SCALE = 100;
   localparam int ACC_W_DEFAULT = 9;

endpackage

// File: rtl/accuracy_tracker_if.sv
// ---------------------------------------------------------------------------
// accuracy_tracker_if
// Result handshake between the last ANN layer / input loader and the tracker.
//   result_valid     : producer has a classified result (held until accepted)
//   result_ready     : tracker can take a result this cycle
//   obtained_output  : one-hot classified output of the last layer
//   expected_output  : one-hot label from the input loader
// Modports: master = producer side, slave = tracker side.
// ---------------------------------------------------------------------------
interface accuracy_tracker_if #(
   parameter int NUM_CLASSES = 10
);

   logic                   result_valid;
   logic                   result_ready;
   logic [NUM_CLASSES-1:0] obtained_output;
   logic [NUM_CLASSES-1:0] expected_output;

   modport master (
      output result_valid,
      output obtained_output,
      output expected_output,
      input  result_ready
   );

   modport slave (
      input  result_valid,
      input  obtained_output,
      input  expected_output,
      output result_ready
   );

endinterface

// File: rtl/accuracy_tracker_seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Restoring unsigned divider, one quotient bit per cycle. The first step is
// performed on the start edge itself, so the quotient is complete DVD_W edges
// after start is sampled; done pulses for one cycle while it is valid.
//   clk, rst  : clock, synchronous active-high reset
//   start     : load dividend/divisor and perform the first step
//   dividend  : DVD_W-bit numerator
//   divisor   : DVS_W-bit denominator (must be nonzero)
//   busy      : further steps outstanding
//   done      : one-cycle pulse, quotient valid
//   quotient  : low QUO_W bits of the quotient
// ---------------------------------------------------------------------------
module seq_divider #(
   parameter int DVD_W = 15,
   parameter int DVS_W = 8,
   parameter int QUO_W = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DVD_W-1:0] dividend,
   input  logic [DVS_W-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [QUO_W-1:0] quotient
);

   localparam int STEP_W = $clog2(DVD_W + 1);

   logic [DVS_W-1:0]  rem_q, rem_d, rem_src, dvs_q, dvs_src;
   logic [DVD_W-1:0]  quo_q, quo_d, quo_src;
   logic [STEP_W-1:0] steps_q;
   logic [DVS_W:0]    trial;

   // One restoring step. On start the step works on the fresh operands so no
   // separate load cycle is spent.
   always_comb begin
      // NOTE: every combinational output gets a value before any branch; a
      // path that leaves one unassigned would infer a latch.
      rem_src = start ? '0 : rem_q;
      quo_src = start ? dividend : quo_q;
      dvs_src = start ? divisor : dvs_q;
      trial   = {rem_src, quo_src[DVD_W-1]};
      rem_d   = trial[DVS_W-1:0];
      quo_d   = {quo_src[DVD_W-2:0], 1'b0};
      if (trial >= {1'b0, dvs_src}) begin
         rem_d = DVS_W'(trial - {1'b0, dvs_src});
         quo_d = {quo_src[DVD_W-2:0], 1'b1};
      end
   end

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the values present before the edge, independent of block order.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         steps_q <= '0;
         done    <= 1'b0;
      end else if (start) begin
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= divisor;
         steps_q <= STEP_W'(DVD_W - 1);
         done    <= (DVD_W == 1);
      end else if (steps_q != '0) begin
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         steps_q <= steps_q - STEP_W'(1);
         done    <= (steps_q == STEP_W'(1));
      end else begin
         done    <= 1'b0;
      end
   end

   assign busy     = (steps_q != '0);
   assign quotient = quo_q[QUO_W-1:0];

endmodule

// File: rtl/accuracy_tracker.sv
// ---------------------------------------------------------------------------
// accuracy_tracker
// Scores classified samples against their labels: counts scored/correct
// samples, computes floor(correct*100/count) with a sequential divider and
// pulses begin_next to request the next sample. Stops after MAX_INPUTS.
//   clk, rst_overall  : clock, synchronous active-high reset
//   enable_inference  : level, permits acceptance of new results
//   res               : result handshake (slave side)
//   match             : compare result of the last accepted sample
//   count             : samples scored
//   correct_count     : samples matched
//   accuracy          : integer percent accuracy, 0..100
//   begin_next        : one-cycle pulse, score updated
//   all_done          : sticky, all samples scored
// ---------------------------------------------------------------------------
module accuracy_tracker
   import ann_pkg::*;
#(
   parameter int NUM_CLASSES = 10,
   parameter int MAX_INPUTS  = 200,
   parameter int CNT_W       = $clog2(MAX_INPUTS + 1),
   parameter int ACC_W       = ACC_W_DEFAULT,
   parameter int DIV_W       = CNT_W + 7
) (
   input  logic               clk,
   input  logic               rst_overall,
   input  logic               enable_inference,
   accuracy_tracker_if.slave  res,
   output logic               match,
   output logic [CNT_W-1:0]   count,
   output logic [CNT_W-1:0]   correct_count,
   output logic [ACC_W-1:0]   accuracy,
   output logic               begin_next,
   output logic               all_done
);

   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(MAX_INPUTS);

   tracker_state_t         state_q, state_d;
   logic [NUM_CLASSES-1:0] obtained_q, expected_q;
   logic                   accept;
   logic                   match_c;
   logic [CNT_W-1:0]       count_inc, correct_inc;
   logic [DIV_W-1:0]       dividend;
   logic                   div_start, div_busy, div_done;
   logic [ACC_W-1:0]       quotient;

   assign accept = (state_q == WAIT_RES) && res.result_valid;

   // An all-zero label never counts as correct, even against an all-zero output.
   assign match_c     = (obtained_q == expected_q) && (expected_q != '0);
   assign count_inc   = count + CNT_W'(1);
   assign correct_inc = correct_count + CNT_W'(match_c);
   // The divider starts in COMPARE, in the same edge the counters update, so
   // it is fed the post-update values rather than the registers.
   assign dividend    = DIV_W'(correct_inc) * DIV_W'(PERCENT_SCALE);
   assign div_start   = (state_q == COMPARE) && !div_busy;

   seq_divider #(
      .DVD_W (DIV_W),
      .DVS_W (CNT_W),
      .QUO_W (ACC_W)
   ) u_div (
      .clk      (clk),
      .rst      (rst_overall),
      .start    (div_start),
      .dividend (dividend),
      .divisor  (count_inc),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (quotient)
   );

   always_comb begin
      state_d          = state_q;
      res.result_ready = 1'b0;
      unique case (state_q)
         IDLE:     if (enable_inference) state_d = WAIT_RES;
         WAIT_RES: begin
            res.result_ready = 1'b1;
            if (res.result_valid)       state_d = COMPARE;
            else if (!enable_inference) state_d = IDLE;
         end
         COMPARE:  state_d = DIVIDE;
         DIVIDE:   if (div_done) state_d = NEXT;
         NEXT: begin
            if (count == LAST_COUNT)    state_d = DONE;
            else if (enable_inference)  state_d = WAIT_RES;
            else                        state_d = IDLE;
         end
         DONE:     state_d = DONE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_overall) state_q <= IDLE;
      else             state_q <= state_d;
   end

   // NOTE: the captured vectors carry no reset; they are always written on
   // accept before COMPARE reads them, so their power-up value is never seen.
   always_ff @(posedge clk) begin
      if (accept) begin
         obtained_q <= res.obtained_output;
         expected_q <= res.expected_output;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_overall) begin
         match         <= 1'b0;
         count         <= '0;
         correct_count <= '0;
         accuracy      <= '0;
         begin_next    <= 1'b0;
         all_done      <= 1'b0;
      end else begin
         begin_next <= 1'b0;
         if (state_q == COMPARE) begin
            match         <= match_c;
            count         <= count_inc;
            correct_count <= correct_inc;
         end
         if (state_q == NEXT) begin
            accuracy   <= quotient;
            begin_next <= 1'b1;
            if (count == LAST_COUNT) all_done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_accuracy_tracker.sv
// ---------------------------------------------------------------------------
// tb_accuracy_tracker
// Scoreboard bench: the driver pushes the expected score for every accepted
// sample; a monitor pops and compares whenever begin_next pulses.
// ---------------------------------------------------------------------------
module tb_accuracy_tracker;

   localparam int NC    = 10;
   localparam int MAX   = 12;
   localparam int CNT_W = $clog2(MAX + 1);
   localparam int ACC_W = 9;
   localparam int DIV_W = CNT_W + 7;

   typedef struct {
      int unsigned     cnt;
      int unsigned     cor;
      int unsigned     acc;
      bit              m;
      bit              done;
      longint unsigned cyc;
   } exp_t;

   logic             clk;
   logic             rst;
   logic             enable;
   logic             match;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] correct_count;
   logic [ACC_W-1:0] accuracy;
   logic             begin_next;
   logic             all_done;

   accuracy_tracker_if #(.NUM_CLASSES(NC)) intf ();

   accuracy_tracker #(
      .NUM_CLASSES (NC),
      .MAX_INPUTS  (MAX),
      .ACC_W       (ACC_W)
   ) dut (
      .clk              (clk),
      .rst_overall      (rst),
      .enable_inference (enable),
      .res              (intf.slave),
      .match            (match),
      .count            (count),
      .correct_count    (correct_count),
      .accuracy         (accuracy),
      .begin_next       (begin_next),
      .all_done         (all_done)
   );

   exp_t            exp_q[$];
   int              n_checks = 0;
   int              n_fail   = 0;
   int unsigned     ref_count   = 0;
   int unsigned     ref_correct = 0;
   int unsigned     last_acc    = 0;
   bit              in_reset    = 1'b1;
   longint unsigned cyc         = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [NC-1:0] onehot(input int unsigned k);
      logic [NC-1:0] v;
      v    = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   // Random label/output pair: mostly one-hot, with identical, different,
   // multi-hot and all-zero outputs and occasional all-zero labels.
   task automatic gen_pair(output logic [NC-1:0] o, output logic [NC-1:0] e);
      int unsigned r;
      r = $urandom_range(0, 9);
      e = onehot($urandom_range(0, NC - 1));
      case (r)
         0, 1, 2, 3, 4: o = e;
         5, 6, 7:       o = onehot($urandom_range(0, NC - 1));
         8:             o = e | onehot($urandom_range(0, NC - 1));
         default: begin
            o = '0;
            if ($urandom_range(0, 1) == 1) e = '0;
         end
      endcase
   endtask

   // Presents one sample, waits for acceptance and records its expected score.
   task automatic send(input logic [NC-1:0] o, input logic [NC-1:0] e,
                       input bit hold, input bit drop_en);
      int   budget;
      exp_t rec;
      intf.obtained_output = o;
      intf.expected_output = e;
      intf.result_valid    = 1'b1;
      budget = 0;
      while (!intf.result_ready && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      if (!intf.result_ready) begin
         check("accept_timeout", 64'd0, 64'd1);
         intf.result_valid = 1'b0;
         return;
      end
      ref_count++;
      if (o == e && e != '0) ref_correct++;
      rec.cnt  = ref_count;
      rec.cor  = ref_correct;
      rec.acc  = (ref_correct * 100) / ref_count;
      rec.m    = (o == e && e != '0);
      rec.done = (ref_count == MAX);
      rec.cyc  = cyc + 1 + DIV_W + 2;
      exp_q.push_back(rec);
      @(posedge clk);
      #1;
      if (!hold)   intf.result_valid = 1'b0;
      if (drop_en) enable = 1'b0;
   endtask

   task automatic wait_drain();
      int b;
      b = 0;
      while (exp_q.size() != 0 && b < 500) begin
         @(negedge clk);
         b++;
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
   endtask

   task automatic do_reset(input int n);
      rst       = 1'b1;
      in_reset  = 1'b1;
      exp_q.delete();
      ref_count   = 0;
      ref_correct = 0;
      last_acc    = 0;
      repeat (n) @(posedge clk);
      #1;
      rst      = 1'b0;
      in_reset = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_match"},    64'(match),             64'd0);
      check({tag, "_count"},    64'(count),             64'd0);
      check({tag, "_correct"},  64'(correct_count),     64'd0);
      check({tag, "_accuracy"}, 64'(accuracy),          64'd0);
      check({tag, "_begin"},    64'(begin_next),        64'd0);
      check({tag, "_done"},     64'(all_done),          64'd0);
      check({tag, "_ready"},    64'(intf.result_ready), 64'd0);
   endtask

   // Monitor: every begin_next must match the oldest outstanding expectation;
   // between pulses the accuracy must hold its last reported value.
   initial begin
      exp_t rec;
      forever begin
         @(negedge clk);
         if (!in_reset) begin
            if (begin_next) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_begin_next", 64'd1, 64'd0);
               end else begin
                  rec = exp_q.pop_front();
                  check("count",         64'(count),         64'(rec.cnt));
                  check("correct_count", 64'(correct_count), 64'(rec.cor));
                  check("accuracy",      64'(accuracy),      64'(rec.acc));
                  check("match",         64'(match),         64'(rec.m));
                  check("all_done",      64'(all_done),      64'(rec.done));
                  check("latency_cycle", 64'(cyc),           64'(rec.cyc));
                  last_acc = rec.acc;
               end
            end else begin
               check("accuracy_hold", 64'(accuracy), 64'(last_acc));
            end
         end
      end
   end

   initial begin
      logic [NC-1:0] o, e;
      bit            drop;

      rst                  = 1'b1;
      enable               = 1'b0;
      intf.result_valid    = 1'b0;
      intf.obtained_output = '0;
      intf.expected_output = '0;

      // Reset held for three edges, inference disabled.
      repeat (3) @(posedge clk);
      #1;
      rst      = 1'b0;
      in_reset = 1'b0;
      @(negedge clk);
      check_zero("reset");
      @(negedge clk);
      check("idle_ready_disabled", 64'(intf.result_ready), 64'd0);
      enable = 1'b1;

      // Single matching sample, then match/mismatch/mismatch.
      send(10'b0000000100, 10'b0000000100, 1'b0, 1'b0);
      wait_drain();
      send(10'b0000000100, 10'b0000001000, 1'b0, 1'b0);
      wait_drain();
      send(10'b0000000000, 10'b0000010000, 1'b0, 1'b0);
      wait_drain();

      // Fourth sample matches with valid held high through the computation.
      send(10'b1000000000, 10'b1000000000, 1'b1, 1'b0);
      repeat (DIV_W) begin
         @(negedge clk);
         check("ready_low_while_busy", 64'(intf.result_ready), 64'd0);
      end
      intf.result_valid = 1'b0;
      wait_drain();

      // Random samples to the limit, back to back, sometimes disabling
      // inference while a sample is in flight.
      for (int i = 0; i < MAX - 4; i++) begin
         gen_pair(o, e);
         drop = ($urandom_range(0, 3) == 0);
         send(o, e, 1'b0, drop);
         if (drop) begin
            wait_drain();
            check("idle_after_drop_a", 64'(intf.result_ready), 64'd0);
            @(negedge clk);
            check("idle_after_drop_b", 64'(intf.result_ready), 64'd0);
            enable = 1'b1;
         end
      end
      wait_drain();

      // Terminated: further valids are ignored and all_done stays high.
      gen_pair(o, e);
      intf.obtained_output = o;
      intf.expected_output = e;
      intf.result_valid    = 1'b1;
      enable               = 1'b1;
      repeat (30) begin
         @(negedge clk);
         check("done_ready",    64'(intf.result_ready), 64'd0);
         check("done_sticky",   64'(all_done),          64'd1);
         check("done_count",    64'(count),             64'(MAX));
      end
      intf.result_valid = 1'b0;

      // Reset from the terminal state, then reset in the middle of a divide.
      @(posedge clk);
      #1;
      do_reset(3);
      @(negedge clk);
      check_zero("reset_from_done");
      enable = 1'b1;
      send(10'b0000100000, 10'b0000100000, 1'b0, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      enable = 1'b0;
      do_reset(1);
      @(negedge clk);
      check_zero("reset_mid_divide");
      repeat (DIV_W + 6) begin
         @(negedge clk);
         check("no_begin_after_reset", 64'(begin_next),        64'd0);
         check("idle_after_reset",     64'(intf.result_ready), 64'd0);
      end

      // Normal scoring resumes after reset.
      enable = 1'b1;
      gen_pair(o, e);
      send(o, e, 1'b0, 1'b0);
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
